// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake in, qualified serial bit stream out
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic in_ready;
  logic valid;
  logic data_out;
  logic busy;
  modport master(output in_valid, in_data, input in_ready, valid, data_out, busy);
  modport slave(input in_valid, in_data, output in_ready, valid, data_out, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial with GAP idle cycles per bit; define PARITY_EN to append an even-parity bit
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  bit_serializer_if.slave io
);
`ifdef PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP} state_t;
  state_t state;
  logic [N-1:0] load, sr, nxt;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic valid, data_out, busy;
`ifdef PARITY_EN
  assign load = MSB_FIRST ? {io.in_data, ^io.in_data} : {^io.in_data, io.in_data};
`else
  assign load = io.in_data;
`endif
  assign nxt = MSB_FIRST ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};
  assign io.in_ready = state == S_IDLE && !rst;
  assign io.valid = valid;
  assign io.data_out = data_out;
  assign io.busy = busy;
  function automatic logic head(input logic [N-1:0] x);
    return MSB_FIRST ? x[N-1] : x[0];
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      valid <= 1'b0;
      data_out <= 1'b0;
      busy <= 1'b0;
      sr <= '0;
      cnt <= '0;
      gcnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (io.in_valid) begin
          state <= S_BIT;
          sr <= load;
          cnt <= CW'(N);
          valid <= 1'b1;
          data_out <= head(load);
          busy <= 1'b1;
        end
        S_BIT: begin
          sr <= nxt;
          cnt <= cnt - 1'b1;
          if (GAP > 0) begin
            state <= S_GAP;
            gcnt <= GW'(GAP);
            valid <= 1'b0;
            data_out <= 1'b0;
          end else if (cnt > CW'(1)) begin
            data_out <= head(nxt);
          end else begin
            state <= S_IDLE;
            valid <= 1'b0;
            data_out <= 1'b0;
            busy <= 1'b0;
          end
        end
        S_GAP: begin
          if (gcnt > GW'(1)) begin
            gcnt <= gcnt - 1'b1;
          end else if (cnt != '0) begin
            state <= S_BIT;
            valid <= 1'b1;
            data_out <= head(sr);
          end else begin
            state <= S_IDLE;
            busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized words on two configurations checked against a per-cycle bit-stream model
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  int sel = 0;
  int npass = 0;
  int ntot = 0;
  always #5 clk = ~clk;
  bit_serializer_if #(.WIDTH(8)) a_if();
  bit_serializer_if #(.WIDTH(8)) b_if();
  assign a_if.in_valid = in_valid && sel == 0;
  assign a_if.in_data = in_data;
  assign b_if.in_valid = in_valid && sel == 1;
  assign b_if.in_data = in_data;
  bit_serializer #(.WIDTH(8), .GAP(1), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .io(a_if.slave));
  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .io(b_if.slave));
  wire rdy = sel == 1 ? b_if.in_ready : a_if.in_ready;
  wire vld = sel == 1 ? b_if.valid : a_if.valid;
  wire dout = sel == 1 ? b_if.data_out : a_if.data_out;
  wire bsy = sel == 1 ? b_if.busy : a_if.busy;
  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic run_word(input logic [7:0] w, input logic hold, input logic [7:0] nxt, input logic imm);
    int g, nb, p, n, det, exp_det, bi;
    logic msb, ev;
    logic [8:0] bits;
    logic [3:0] mh, oh;
    g = sel == 1 ? 0 : 1;
    msb = sel == 0;
`ifdef PARITY_EN
    nb = 9;
`else
    nb = 8;
`endif
    bits = '0;
    for (int i = 0; i < nb; i++) bits[i] = i < 8 ? (msb ? w[7-i] : w[i]) : ^w;
    exp_det = 0;
    mh = '0;
    for (int i = 0; i < nb; i++) begin
      mh = {mh[2:0], bits[i]};
      if (mh == 4'b1101) exp_det++;
    end
    p = nb * (1 + g) + 1;
    in_valid = 1'b1;
    in_data = w;
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", int'(n < 50), 1);
    if (imm) chk("held_accept_latency", n, 0);
    @(posedge clk);
    det = 0;
    oh = '0;
    for (int k = 0; k < p - 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_data = nxt;
        in_valid = hold;
      end
      ev = (k % (1 + g)) == 0;
      bi = k / (1 + g);
      chk("valid", int'(vld), int'(ev));
      chk("data_out", int'(dout), ev ? int'(bits[bi]) : 0);
      chk("busy", int'(bsy), 1);
      chk("in_ready_busy", int'(rdy), 0);
      if (vld) begin
        oh = {oh[2:0], dout};
        if (oh == 4'b1101) det++;
      end
    end
    @(negedge clk);
    chk("in_ready_back", int'(rdy), 1);
    chk("busy_idle", int'(bsy), 0);
    chk("valid_idle", int'(vld), 0);
    chk("det_1101", det, exp_det);
  endtask
  initial begin
    int n;
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", int'(rdy), 0);
      chk("rst_valid", int'(vld), 0);
      chk("rst_data_out", int'(dout), 0);
      chk("rst_busy", int'(bsy), 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("in_ready_after_rst", int'(rdy), 1);
    @(negedge clk);
    run_word(8'hD6, 1'b0, 8'($urandom), 1'b0);
    run_word(8'hD6, 1'b1, 8'h0D, 1'b0);
    run_word(8'h0D, 1'b0, 8'($urandom), 1'b1);
    run_word(8'h0F, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) run_word(8'($urandom), 1'b0, 8'($urandom), 1'b0);
    sel = 1;
    @(negedge clk);
    run_word(8'hB0, 1'b0, 8'($urandom), 1'b0);
    run_word(8'hD6, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) run_word(8'($urandom), 1'b0, 8'($urandom), 1'b0);
    sel = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'($urandom);
    n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_accept_wait", int'(n < 50), 1);
    @(posedge clk);
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", int'(vld), 0);
    chk("midrst_data_out", int'(dout), 0);
    chk("midrst_busy", int'(bsy), 0);
    chk("midrst_in_ready", int'(rdy), 0);
    rst = 1'b0;
    run_word(8'hD6, 1'b0, 8'($urandom), 1'b0);
    run_word(8'($urandom), 1'b0, 8'($urandom), 1'b0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end for the serial pattern detectors in the FSM block group. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit at a time. Each emitted bit is qualified by a valid strobe, with a programmable number of idle cycles between bits. Its valid/data_out outputs drive the valid/data_in inputs of a downstream sequence detector directly.

Parameters:
WIDTH, 8, bits per input word (>=2)
GAP, 1, idle cycles (valid=0) inserted after every emitted bit (>=0)
MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream word available
in_data  input  WIDTH  upstream word, sampled on accept edge
in_ready  output  1  block can accept a word
valid  output  1  data_out carries a real bit this cycle (to detector valid)
data_out  output  1  serial bit (to detector data_in)
busy  output  1  word in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high. All state changes occur on posedge clk.
- Reset: state=IDLE, valid=0, data_out=0, busy=0, shift register and counters cleared. in_ready=0 while rst=1.
- in_ready is combinational: (state==IDLE) && !rst. valid, data_out and busy are registered.
- Accept: in_valid && in_ready at a posedge.
  - The word is loaded.
  - The first bit is driven on valid=1/data_out in the cycle immediately after that edge, so latency is 0 extra cycles.
- States: IDLE, BIT, GAP.
  - IDLE: valid=0, data_out=0. On accept -> BIT, bit counter=WIDTH.
  - BIT: valid=1, data_out=current bit. On the next edge, decrement the bit counter and shift.
    - If GAP>0 -> GAP with gap counter=GAP.
    - Else, if bits remain -> BIT.
    - Else -> IDLE.
  - GAP: valid=0, data_out=0 (no stale data), held for GAP cycles. Then -> BIT if bits remain, else -> IDLE.
- Counters are sized $clog2(WIDTH+2) and $clog2(GAP+1) (minimum 1 bit).
- Word period: WIDTH*(1+GAP)+1 cycles (the +1 is the IDLE cycle that shows in_ready). There is no back-to-back overlap.
- in_valid while busy: ignored. Upstream must hold in_data until accepted. in_data changes while busy have no effect.
- Reset mid-word: the word is discarded and all outputs take their reset values on that edge. The downstream detector is expected to be reset on the same rst.
- With GAP=0, valid stays high continuously for WIDTH (or WIDTH+1) cycles.

Optional Feature:
Macro PARITY_EN.
- Defined: after the WIDTH data bits, one extra even-parity bit (XOR of all WIDTH bits of the accepted word) is emitted in BIT with valid=1, followed by GAP idle cycles like any data bit. Word period becomes (WIDTH+1)*(1+GAP)+1.
- Undefined: only WIDTH data bits are emitted. No parity logic is present.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, valid=0, data_out=0, busy=0 throughout. in_ready=1 in the first cycle after rst drops.
- Single word, defaults (WIDTH=8, GAP=1, MSB_FIRST=1): in_data=8'hD6 accepted at edge 0.
  - valid=1 in cycles 0,2,...,14 with data_out=1,1,0,1,0,1,1,0.
  - valid=0 and data_out=0 in odd cycles.
  - in_ready=1 again in cycle 16.
  - A chained moore 1101 detector reports exactly 1 detection.
- Held in_valid: in_valid held with 8'hD6 then 8'h0D -> second word accepted exactly 17 cycles after the first. Bits 0,0,0,0,1,1,0,1 follow. in_data changes during busy are ignored.
- GAP=0, MSB_FIRST=0, in_data=8'hB0 -> valid high for 8 consecutive cycles with data_out=0,0,0,0,1,1,0,1. in_ready=1 in cycle 8.
- Mid-word reset: rst=1 during cycle 5 of a word -> next cycle state IDLE, valid=0, busy=0. The following word serializes from its first bit with no residue.
- PARITY_EN defined, 8'hD6 (five ones) -> ninth valid bit=1 in cycle 16, in_ready in cycle 18. With 8'h0F -> parity bit=0.
